mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between two requesters: the instruction-fetch path (IF) and the load/store path (LS) of the multicycle RV32I core.
- Arbitrates with round-robin or fixed LS priority and latches the winning request.
- Drives the memory until mem_ready is returned, then routes the read data and a completion pulse back to the owning requester.
- A watchdog aborts transfers that never complete and flags a bus error.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port unified memory of the multicycle
// RV32I core. The instruction-fetch (IF) and load/store (LS) paths compete
// for the memory. The winner's request is latched and the memory is driven
// until mem_ready. Read data and a completion pulse then go back to the owner.
// A watchdog aborts an access that never completes and flags bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,   // 1: round-robin on ties, 0: LS wins ties
  parameter int TIMEOUT = 16   // max BUSY cycles before abort, 0 disables
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store requester
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  // abort indication, pulses together with if_rvalid/ls_done
  output logic              bus_err,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic { S_IDLE, S_BUSY } state_t;
  typedef enum logic { OWN_IF, OWN_LS } owner_t;

  state_t              state_q;
  owner_t              owner_q;
  owner_t              last_owner_q;
  logic [WAIT_W-1:0]   wait_cnt_q;

  logic                if_gnt_q;
  logic                ls_gnt_q;
  logic                if_rvalid_q;
  logic                ls_done_q;
  logic                bus_err_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;

  logic                win_ls_d;
  logic                timeout_hit_d;

  // Pick the winner of the current IDLE arbitration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    win_ls_d = 1'b0;
    if (ls_req && !if_req) begin
      win_ls_d = 1'b1;
    end else if (ls_req && if_req) begin
      win_ls_d = (RR_EN != 0) ? (last_owner_q == OWN_IF) : 1'b1;
    end
  end

  // Watchdog expiry: this BUSY cycle is the last one allowed.
  assign timeout_hit_d = (TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST);

  // Arbitration FSM with registered grant, completion and memory outputs.
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;   // first tie after reset goes to IF
      wait_cnt_q   <= '0;
      if_gnt_q     <= 1'b0;
      ls_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      ls_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (if_req || ls_req) begin
            state_q    <= S_BUSY;
            mem_en_q   <= 1'b1;
            wait_cnt_q <= '0;
            if (win_ls_d) begin
              owner_q     <= OWN_LS;
              ls_gnt_q    <= 1'b1;
              mem_we_q    <= ls_we;
              mem_addr_q  <= ls_addr;
              mem_wdata_q <= ls_wdata;
            end else begin
              owner_q    <= OWN_IF;
              if_gnt_q   <= 1'b1;
              mem_we_q   <= 1'b0;      // fetches are always reads
              mem_addr_q <= if_addr;
            end
          end
        end

        S_BUSY: begin
          // mem_ready wins over an expiring watchdog on the same edge.
          if (mem_ready || timeout_hit_d) begin
            state_q      <= S_IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            wait_cnt_q   <= '0;
            last_owner_q <= owner_q;
            bus_err_q    <= !mem_ready;
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if (mem_ready) begin
                if_rdata_q <= mem_rdata;
              end
            end else begin
              ls_done_q <= 1'b1;
              if (mem_ready && !mem_we_q) begin
                ls_rdata_q <= mem_rdata;
              end
            end
          end else if (TIMEOUT > 0) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_done   = ls_done_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance u_rr uses round-robin with
// TIMEOUT=4. Instance u_fix uses fixed LS priority. Both instances see the
// same stimulus. Outputs are sampled 1 ns after the rising edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we, mem_ready;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, mem_rdata;

  logic          a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_done, a_bus_err, a_mem_en, a_mem_we;
  logic [DW-1:0] a_if_rdata, a_ls_rdata, a_mem_wdata;
  logic [AW-1:0] a_mem_addr;

  logic          b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_done, b_bus_err, b_mem_en, b_mem_we;
  logic [DW-1:0] b_if_rdata, b_ls_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1), .TIMEOUT(4)) u_rr (
    .arb_clk(clk), .arb_rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_done(a_ls_done), .ls_rdata(a_ls_rdata),
    .bus_err(a_bus_err),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0), .TIMEOUT(4)) u_fix (
    .arb_clk(clk), .arb_rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_done(b_ls_done), .ls_rdata(b_ls_rdata),
    .bus_err(b_bus_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    if_req    = 1'b0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    mem_ready = 1'b0;
    if_addr   = '0;
    ls_addr   = '0;
    ls_wdata  = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    rst = 1'b1;
    #1;
    check("rst_outputs", {a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_done, a_bus_err, a_mem_en, a_mem_we}, 32'd0);
    check("rst_addr", a_mem_addr, 32'd0);
    check("rst_wdata", a_mem_wdata, 32'd0);
    check("rst_rdata", a_if_rdata | a_ls_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- single fetch ----------------
    // mem_ready is held high in IDLE as well. It must be ignored there.
    if_req    = 1'b1;
    if_addr   = 32'h100;
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    tick();
    check("fetch_gnt", {a_if_gnt, a_ls_gnt}, 32'b10);
    check("fetch_mem_en", {a_mem_en, a_mem_we}, 32'b10);
    check("fetch_addr", a_mem_addr, 32'h100);
    check("fetch_no_early_rvalid", a_if_rvalid, 32'd0);
    if_req = 1'b0;
    tick();
    check("fetch_gnt_one_cycle", a_if_gnt, 32'd0);
    check("fetch_rvalid", {a_if_rvalid, a_bus_err, a_mem_en}, 32'b100);
    check("fetch_rdata", a_if_rdata, 32'h0050_0093);
    tick();
    check("fetch_rvalid_one_cycle", {a_if_rvalid, a_mem_en, a_if_gnt}, 32'd0);
    mem_ready = 1'b0;

    // ---------------- store with wait states ----------------
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h200;
    ls_wdata = 32'hDEAD_BEEF;
    tick();
    check("store_gnt", {a_ls_gnt, a_if_gnt}, 32'b10);
    ls_req    = 1'b0;
    ls_wdata  = 32'h0;
    ls_addr   = 32'h0;
    mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("store_busy%0d_ctl", c), {a_mem_en, a_mem_we, a_ls_done}, 32'b110);
      check($sformatf("store_busy%0d_addr", c), a_mem_addr, 32'h200);
      check($sformatf("store_busy%0d_wdata", c), a_mem_wdata, 32'hDEAD_BEEF);
      if (c == 2) mem_ready = 1'b1;
      tick();
    end
    check("store_done", {a_ls_done, a_bus_err, a_mem_en, a_mem_we}, 32'b1000);
    check("store_rdata_held", a_ls_rdata, 32'd0);
    mem_ready = 1'b0;
    tick();
    check("store_done_one_cycle", a_ls_done, 32'd0);

    // ---------------- ties: both requests held ----------------
    do_reset();
    if_req    = 1'b1;
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    if_addr   = 32'h400;
    ls_addr   = 32'h800;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0A0A;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), {a_if_gnt, a_ls_gnt}, (k % 2 == 0) ? 32'b10 : 32'b01);
      check($sformatf("fix_gnt%0d", k), {b_if_gnt, b_ls_gnt}, 32'b01);
      tick();
      check($sformatf("rr_cmpl%0d", k), {a_if_rvalid, a_ls_done, a_if_gnt, a_ls_gnt},
            (k % 2 == 0) ? 32'b1000 : 32'b0100);
      check($sformatf("fix_cmpl%0d", k), {b_if_rvalid, b_ls_done, b_if_gnt, b_ls_gnt}, 32'b0100);
    end
    if_req    = 1'b0;
    ls_req    = 1'b0;
    mem_ready = 1'b0;

    // ---------------- watchdog abort ----------------
    do_reset();
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    ls_addr   = 32'h300;
    mem_rdata = 32'hAAAA_5555;
    tick();
    check("to_gnt", a_ls_gnt, 32'd1);
    ls_req = 1'b0;
    for (int c = 1; c < 4; c++) begin
      tick();
      check($sformatf("to_busy%0d", c), {a_mem_en, a_ls_done, a_bus_err}, 32'b100);
    end
    tick();
    check("to_abort", {a_ls_done, a_bus_err, a_mem_en}, 32'b110);
    check("to_rdata_held", a_ls_rdata, 32'd0);
    tick();
    check("to_abort_one_cycle", {a_ls_done, a_bus_err}, 32'd0);

    // mem_ready arrives on the last allowed cycle, so the access completes normally
    ls_req = 1'b1;
    tick();
    check("to2_gnt", a_ls_gnt, 32'd1);
    ls_req = 1'b0;
    repeat (3) tick();
    check("to2_still_busy", {a_mem_en, a_ls_done}, 32'b10);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("to2_done", {a_ls_done, a_bus_err, a_mem_en}, 32'b100);
    check("to2_rdata", a_ls_rdata, 32'hCAFE_F00D);
    mem_ready = 1'b0;

    // ---------------- async reset mid-BUSY ----------------
    do_reset();
    ls_req  = 1'b1;
    ls_addr = 32'h500;
    tick();
    check("ar_gnt", a_ls_gnt, 32'd1);
    ls_req = 1'b0;
    tick();
    check("ar_busy", a_mem_en, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_immediate", {a_mem_en, a_ls_gnt, a_ls_done, a_if_rvalid, a_bus_err}, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #3;
    rst       = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("ar_no_stale", {a_ls_done, a_if_rvalid, a_bus_err, a_mem_en}, 32'd0);
    tick();
    check("ar_no_stale2", {a_ls_done, a_if_rvalid, a_bus_err}, 32'd0);
    if_req    = 1'b1;
    ls_req    = 1'b1;
    if_addr   = 32'h600;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    check("ar_tie_if_wins", {a_if_gnt, a_ls_gnt}, 32'b10);
    check("ar_addr", a_mem_addr, 32'h600);
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    check("ar_rvalid", {a_if_rvalid, a_bus_err}, 32'b10);
    check("ar_rdata", a_if_rdata, 32'h0BAD_F00D);
    mem_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
